// File: rtl/traffic_gen.sv
// traffic_gen: pseudo-random elevator hall-call generator with valid/ready handshake.
// Ports: clk/reset_n (async active-low) clock and reset; enable gates generation and LFSR;
// mode selects MORNING/LUNCH/NORMAL floor mix; interval sets cycles from accept to next offer;
// req_valid/req_ready handshake with req_floor/req_dir payload; req_count counts accepts (saturating).
module traffic_gen #(
  parameter int          NUM_FLOORS = 8,
  parameter int          FLOOR_W    = 3,
  parameter int          INTERVAL_W = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [INTERVAL_W-1:0] interval,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic                  req_dir,
  output logic [15:0]           req_count
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OFFER} state_e;
  localparam logic [15:0]         LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [FLOOR_W-1:0]  TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0]  NF_WRAP   = FLOOR_W'(NUM_FLOORS);
  state_e                  state_q, state_d;
  logic [INTERVAL_W-1:0]   cnt_q, cnt_d, load_val;
  logic [15:0]             lfsr_q, lfsr_d, count_q, count_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d, raw_floor, rand_floor, pick_floor;
  logic                    dir_q, dir_d, dflt_dir, to_ground, pick_dir;
  always_comb begin
    load_val   = (interval == '0) ? INTERVAL_W'(1) : interval;
    lfsr_d     = enable ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;
    raw_floor  = lfsr_q[FLOOR_W+7:8];
    // raw values past the top floor fold back by NUM_FLOORS (only reachable when NUM_FLOORS < 2^FLOOR_W)
    rand_floor = (32'(raw_floor) < NUM_FLOORS) ? raw_floor : raw_floor - NF_WRAP;
    dflt_dir   = (rand_floor == '0) ? 1'b1 : (rand_floor == TOP_FLOOR) ? 1'b0 : lfsr_q[2];
    to_ground  = (mode == 2'd0 && lfsr_q[1:0] != 2'b00) || (mode == 2'd1 && lfsr_q[0]);
    pick_floor = to_ground ? '0 : rand_floor;
    pick_dir   = to_ground ? 1'b1 : (mode == 2'd1) ? (rand_floor == '0) : dflt_dir;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_INIT;
      count_q <= '0;
      floor_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      count_q <= count_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: if (enable) begin
        state_d = S_WAIT;
        cnt_d   = load_val;
      end
      S_WAIT: if (!enable) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else if (cnt_q == INTERVAL_W'(1)) begin
        state_d = S_OFFER;
        floor_d = pick_floor;
        dir_d   = pick_dir;
      end else begin
        cnt_d = cnt_q - INTERVAL_W'(1);
      end
      // an offer is held, independent of enable, until the consumer takes it
      S_OFFER: if (req_ready) begin
        count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        state_d = enable ? S_WAIT : S_IDLE;
        cnt_d   = enable ? load_val : '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    req_valid = (state_q == S_OFFER);
    req_floor = floor_q;
    req_dir   = dir_q;
    req_count = count_q;
  end
endmodule

// File: tb/tb_traffic_gen.sv
// tb_traffic_gen: randomized and directed checks of traffic_gen against a timeline reference model.
module tb_traffic_gen;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd2;
  logic [7:0] interval = 8'd1;
  logic       req_ready = 1'b0;
  logic       v8, d8, v6, d6;
  logic [2:0] f8, f6;
  logic [15:0] c8, c6;

  traffic_gen dut8 (.clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .interval(interval),
                    .req_valid(v8), .req_ready(req_ready), .req_floor(f8), .req_dir(d8), .req_count(c8));
  traffic_gen #(.NUM_FLOORS(6), .FLOOR_W(3)) dut6 (.clk(clk), .reset_n(reset_n), .enable(enable),
                    .mode(mode), .interval(interval), .req_valid(v6), .req_ready(req_ready),
                    .req_floor(f6), .req_dir(d6), .req_count(c6));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // reference model: absolute edge number of the next offer instead of a countdown
  logic [15:0] lfsr_m;
  int edge_n, due, cnt_m, f8_m, f6_m;
  bit off_m, d8_m, d6_m, acc_m;
  int last_f8, last_f6;
  bit last_d8, last_d6;
  int acc_n, zero_n, viol8, viol6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void pick(input logic [15:0] l, input int nf, input logic [1:0] md,
                               output int fl, output bit dr);
    int raw, rf;
    bit dd;
    raw = int'(l[10:8]);
    rf  = (raw < nf) ? raw : raw - nf;
    dd  = (rf == 0) ? 1'b1 : (rf == nf - 1) ? 1'b0 : l[2];
    if ((md == 2'd0 && l[1:0] != 2'b00) || (md == 2'd1 && l[0])) begin
      fl = 0; dr = 1'b1;
    end else if (md == 2'd1) begin
      fl = rf; dr = (rf == 0);
    end else begin
      fl = rf; dr = dd;
    end
  endfunction

  task automatic model_edge(input bit en, input logic [1:0] md, input logic [7:0] iv, input bit rdy);
    int i;
    i = (iv == 8'd0) ? 1 : int'(iv);
    edge_n++;
    acc_m = 1'b0;
    if (off_m) begin
      if (rdy) begin
        acc_m = 1'b1;
        cnt_m = (cnt_m == 65535) ? cnt_m : cnt_m + 1;
        off_m = 1'b0;
        due   = en ? edge_n + i : -1;
      end
    end else if (due < 0) begin
      if (en) due = edge_n + i;
    end else if (!en) begin
      due = -1;
    end else if (edge_n == due) begin
      off_m = 1'b1;
      due   = -1;
      pick(lfsr_m, 8, md, f8_m, d8_m);
      pick(lfsr_m, 6, md, f6_m, d6_m);
    end
    if (en) lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(enable, mode, interval, req_ready);
    if (acc_m) begin
      acc_n++;
      if (last_f8 == 0) zero_n++;
      if ((last_f8 == 0 && !last_d8) || (last_f8 == 7 && last_d8)) viol8++;
      if ((last_f6 == 0 && !last_d6) || (last_f6 == 5 && last_d6) || last_f6 >= 6) viol6++;
    end
    #1;
    chk("valid8", v8, off_m);
    chk("valid6", v6, off_m);
    if (off_m) begin
      chk("floor8", f8, f8_m);
      chk("dir8", d8, d8_m);
      chk("floor6", f6, f6_m);
      chk("dir6", d6, d6_m);
      last_f8 = f8; last_d8 = d8; last_f6 = f6; last_d6 = d6;
    end
    chk("count8", c8, cnt_m);
    chk("count6", c6, cnt_m);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    lfsr_m = 16'hACE1; due = -1; off_m = 1'b0; cnt_m = 0;
    chk("rst_valid8", v8, 0);
    chk("rst_count8", c8, 0);
    chk("rst_floor8", f8, 0);
    chk("rst_dir8", d8, 0);
    chk("rst_valid6", v6, 0);
    chk("rst_count6", c6, 0);
    #1 reset_n = 1'b1;
  endtask

  task automatic clear_tally();
    acc_n = 0; zero_n = 0; viol8 = 0; viol6 = 0;
  endtask

  initial begin
    int first_v, bad, cf, cd, k;
    edge_n = 0;
    #1 do_reset();
    // steady NORMAL traffic at interval 4 with an always-ready consumer
    mode = 2'd2; interval = 8'd4; req_ready = 1'b1; enable = 1'b1;
    first_v = -1;
    for (int e = 0; e <= 50; e++) begin
      step();
      if (v8 && first_v < 0) first_v = e;
    end
    chk("first_offer_edge", first_v, 4);
    chk("count_after_50", c8, 10);
    // back-pressure: offer must hold steady while not accepted
    do_reset();
    interval = 8'd3; req_ready = 1'b0; mode = 2'($urandom_range(0, 3));
    k = 0;
    while (!v8 && k < 20) begin step(); k++; end
    chk("hold_offer_seen", v8, 1);
    cf = f8; cd = d8; bad = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (v8 !== 1'b1 || f8 !== 3'(cf) || d8 !== cd[0]) bad++;
    end
    chk("hold_stable", bad, 0);
    chk("hold_count0", c8, 0);
    req_ready = 1'b1;
    step();
    chk("hold_count1", c8, 1);
    // randomized enable / mode / interval / ready
    for (int n = 0; n < 400; n++) begin
      enable = ($urandom_range(0, 9) != 0);
      mode = 2'($urandom_range(0, 3));
      interval = 8'($urandom_range(0, 5));
      req_ready = 1'($urandom_range(0, 1));
      step();
    end
    // enable dropped while waiting, then while offering
    do_reset();
    interval = 8'd5; req_ready = 1'b1; mode = 2'd2; enable = 1'b1;
    step(); step();
    enable = 1'b0; bad = 0;
    for (int n = 0; n < 10; n++) begin step(); if (v8) bad++; end
    chk("wait_drop_no_offer", bad, 0);
    enable = 1'b1; req_ready = 1'b0; k = 0;
    while (!v8 && k < 20) begin step(); k++; end
    chk("offer_seen", v8, 1);
    enable = 1'b0; bad = 0;
    for (int n = 0; n < 5; n++) begin step(); if (!v8) bad++; end
    chk("offer_held_disabled", bad, 0);
    req_ready = 1'b1;
    step();
    chk("offer_taken_idle", v8, 0);
    bad = 0;
    for (int n = 0; n < 5; n++) begin step(); if (v8) bad++; end
    chk("idle_after_take", bad, 0);
    enable = 1'b1;
    for (int n = 0; n < 30; n++) begin req_ready = 1'($urandom_range(0, 1)); step(); end
    // MORNING bias over 1000 accepts
    do_reset();
    mode = 2'd0; interval = 8'd1; req_ready = 1'b1; enable = 1'b1;
    clear_tally(); k = 0;
    while (acc_n < 1000 && k < 5000) begin step(); k++; end
    chk("morning_accepts", acc_n, 1000);
    chk("morning_ground_70pct", (zero_n * 10 >= acc_n * 7), 1);
    chk("morning_dir_rule8", viol8, 0);
    chk("morning_dir_rule6", viol6, 0);
    // LUNCH on six floors
    do_reset();
    mode = 2'd1; clear_tally();
    for (int n = 0; n < 600; n++) step();
    chk("lunch_accepts_seen", (acc_n > 100), 1);
    chk("lunch_six_floor_rules", viol6, 0);
    chk("lunch_dir_rule8", viol8, 0);
    // reset pulse in the middle of an offer with five accepts counted
    do_reset();
    mode = 2'd2; interval = 8'd2; req_ready = 1'b1; k = 0;
    while (c8 != 16'd5 && k < 100) begin step(); k++; end
    chk("pre_reset_count", c8, 5);
    req_ready = 1'b0; k = 0;
    while (!v8 && k < 20) begin step(); k++; end
    chk("pre_reset_offer", v8, 1);
    do_reset();
    req_ready = 1'b1;
    for (int n = 0; n < 20; n++) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
